muldiv_seq: RTL and testbench

Multi-cycle RV32M multiply/divide unit for the execute stage. It sits beside the single-cycle ALU and takes over the `alu_op[4:3]==2'b10` operations when the ALU is built without its combinational multiplier/divider. It accepts one operation over a valid/ready handshake and computes it with a radix-2 iterative datapath. The registered 32-bit result goes to writeback over a second valid/ready handshake.

---
 rtl/muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in one cycle with a combinational multiplier.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic [31:0] res_q, res_d;

  // Operand preparation at accept
  logic [2:0]  op_in;
  logic        is_m, is_div, a_sgn, b_sgn, a_neg, b_neg, sign_in;
  logic        div_zero, div_ovf, special;
  logic [31:0] a_abs, b_abs, special_res;

  assign op_in   = alu_op[2:0];
  assign is_m    = (alu_op[4:3] == 2'b10);
  assign is_div  = op_in[2];
  assign a_sgn   = (op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100) || (op_in == 3'b110);
  assign b_sgn   = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
  assign a_neg   = a_sgn & alu_a[31];
  assign b_neg   = b_sgn & alu_b[31];
  assign a_abs   = a_neg ? (32'd0 - alu_a) : alu_a;
  assign b_abs   = b_neg ? (32'd0 - alu_b) : alu_b;
  // Remainder takes the dividend's sign; products and quotients take the XOR.
  assign sign_in = (is_div && op_in[1]) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = is_div && (alu_b == 32'd0);
  assign div_ovf  = is_div && !op_in[0] && (alu_a == 32'h8000_0000) && (alu_b == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic [32:0] fast_a, fast_b;
  logic [63:0] fast_prod;
  assign fast_a    = {a_sgn & alu_a[31], alu_a};
  assign fast_b    = {b_sgn & alu_b[31], alu_b};
  assign fast_prod = 64'($signed(fast_a) * $signed(fast_b));
  assign special   = !is_m || div_zero || div_ovf || !is_div;
`else
  assign special   = !is_m || div_zero || div_ovf;
`endif

  always_comb begin
    special_res = 32'd0;
    if (!is_m)
      special_res = 32'd0;
    else if (div_zero)
      special_res = op_in[1] ? alu_a : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_res = op_in[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div)
      special_res = (op_in == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
`endif
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum, div_top;
  logic [31:0] div_sub;
  logic [63:0] mul_next, div_next, step_next, prod_fix;
  logic [31:0] div_val, calc_res;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_top   = acc_q[63:31];
  assign div_sub   = div_top[31:0] - b_q;
  assign div_next  = (div_top >= {1'b0, b_q}) ? {div_sub, acc_q[30:0], 1'b1}
                                              : {div_top[31:0], acc_q[30:0], 1'b0};
  assign step_next = op_q[2] ? div_next : mul_next;
  assign prod_fix  = neg_q ? (64'd0 - step_next) : step_next;
  assign div_val   = op_q[1] ? step_next[63:32] : step_next[31:0];

  always_comb begin
    calc_res = 32'd0;
    if (op_q[2])
      calc_res = neg_q ? (32'd0 - div_val) : div_val;
    else if (op_q == 3'b000)
      calc_res = prod_fix[31:0];
    else
      calc_res = prod_fix[63:32];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op_in;
          b_d     = b_abs;
          neg_d   = sign_in;
          acc_d   = {32'd0, a_abs};
          cnt_d   = 6'd0;
          state_d = special ? DONE : CALC;
          if (special)
            res_d = special_res;
        end
      end
      CALC: begin
        acc_d = step_next;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          res_d   = calc_res;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      b_q     <= 32'd0;
      neg_q   <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == CALC);
  assign out_valid  = (state_q == DONE);
  assign alu_result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latencies, backpressure, flush and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHU = 5'b10011;
  localparam logic [4:0] OP_DIV = 5'b10100, OP_DIVU = 5'b10101, OP_REM = 5'b10110;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result), .busy(busy)
  );

  // Issue one op, wait (bounded) for out_valid, consume it. lat = cycles from accept to out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = alu_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("op=%b a=%h b=%h -> result=%h latency=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (alu_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", alu_result); end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [3] = '{OP_MUL, OP_MULH, OP_MULHU};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'd2, res, lat);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [3] = '{OP_DIV, OP_REM, OP_DIVU};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], 32'd2, res, lat);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [4:0]  ops [5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, 5'b00011};
    logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++; if (lat != 1) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt = 0;
    int bad = 0;
    alu_op = OP_DIVU; alu_a = 32'd7; alu_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    while (!out_valid && wait_cnt < 100) begin @(posedge clk); #1 wait_cnt++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || alu_result !== 32'd3 || in_ready !== 1'b0) bad++;
    end
    $display("backpressure hold: result=%h out_valid=%b in_ready=%b", alu_result, out_valid, in_ready);
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d_bad_cycles exp=0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    int seen = 0;
    alu_op = OP_DIVU; alu_a = 32'd100; alu_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    if (out_valid) seen++;
    $display("flush: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    repeat (40) begin @(posedge clk); #1 if (out_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_out_valid got=%0d exp=0", seen); end
    // flush beats in_valid while idle
    alu_op = OP_DIVU; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL flush_idle_accept got=%b%b exp=10", in_ready, busy); end
    run_op(OP_DIVU, 32'd100, 32'd7, res, lat);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL flush_after_result got=%h exp=0000000e", res); end
    checks++; if (lat != 33) begin failures++; $display("FAIL flush_after_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_rst_mid();
    alu_op = OP_DIVU; alu_a = 32'd100; alu_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    $display("rst mid-op: in_ready=%b busy=%b out_valid=%b result=%h", in_ready, busy, out_valid, alu_result);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (alu_result !== 32'd0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", alu_result); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 5'd0; alu_a = 32'd0; alu_b = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
